output_deskew: RTL and testbench

//  Receive end of the systolic-array skew path. Input operands are skewed by

---
 rtl/output_deskew_if.sv | 24 ++
 rtl/output_deskew.sv | 75 +++++++
 tb/tb_output_deskew.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/output_deskew_if.sv
`timescale 1ns/1ps
// Column-skewed result bus entering the deskew block and the aligned vector leaving it.
interface output_deskew_if #(
    parameter int COLS  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
);
    logic [COLS-1:0]       in_valid;
    logic [COLS*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [COLS*WIDTH-1:0] out_data;
    logic [CNTW-1:0]       out_count;
    logic                  misalign_err;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_count, misalign_err
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_count, misalign_err
    );
endinterface

// File: rtl/output_deskew.sv
`timescale 1ns/1ps
// Undoes the systolic-array output skew: column c passes through COLS-c register
// stages so that all lanes of one result vector emerge together with one strobe.
module output_deskew #(
    parameter int COLS  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    output_deskew_if.slave bus
);

    logic [COLS-1:0]       av;
    logic [COLS*WIDTH-1:0] ad;

    // Each lane holds COLS-1-c delay stages; the shared output register is the final stage.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int P = COLS - 1 - c;
        logic [WIDTH:0] entry;

        assign entry = bus.in_valid[c] ? {1'b1, bus.in_data[c*WIDTH +: WIDTH]} : '0;

        if (P == 0) begin : g_direct
            assign av[c]                 = entry[WIDTH];
            assign ad[c*WIDTH +: WIDTH]  = entry[WIDTH-1:0];
        end else begin : g_chain
            logic [WIDTH:0] stage [P];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < P; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= entry;
                    for (int i = 1; i < P; i++) stage[i] <= stage[i-1];
                end
            end

            assign av[c]                 = stage[P-1][WIDTH];
            assign ad[c*WIDTH +: WIDTH]  = stage[P-1][WIDTH-1:0];
        end
    end

    logic all_valid;
    logic mixed;

    assign all_valid = &av;
    assign mixed     = (|av) & ~all_valid;

    logic                  out_valid_q;
    logic [COLS*WIDTH-1:0] out_data_q;
    logic [CNTW-1:0]       out_count_q;
    logic                  err_q;

    // A partially valid slot is dropped and only raises the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= all_valid;
            out_data_q  <= all_valid ? ad : '0;
            if (all_valid) out_count_q <= out_count_q + CNTW'(1);
            if (mixed)     err_q       <= 1'b1;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_count    = out_count_q;
    assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_output_deskew.sv
`timescale 1ns/1ps
// Directed bench for output_deskew (COLS=4, WIDTH=8); a CNTW=4 copy watches counter wrap.
module tb_output_deskew;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    output_deskew_if #(.COLS(4), .WIDTH(8), .CNTW(16)) bus ();
    output_deskew_if #(.COLS(4), .WIDTH(8), .CNTW(4))  bus4 ();

    assign bus4.in_valid = bus.in_valid;
    assign bus4.in_data  = bus.in_data;

    output_deskew #(.COLS(4), .WIDTH(8), .CNTW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    output_deskew #(.COLS(4), .WIDTH(8), .CNTW(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane(input int k, input int c);
        logic [3:0] kk;
        logic [3:0] cc;
        kk = k[3:0];
        cc = c[3:0];
        return {kk, cc};
    endfunction

    task automatic do_reset();
        reset        = 1'b0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          m;
        int          k;
        int          ek;
        logic [31:0] expd;
        logic        expv;
        int          expc;

        reset        = 1'b0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        #12;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data",  bus.out_data, 32'd0);
        check("rst_count", {16'd0, bus.out_count}, 32'd0);
        check("rst_err",   {31'd0, bus.misalign_err}, 32'd0);

        // single vector
        do_reset();
        for (int n = 0; n < 20; n++) begin
            bus.in_valid = '0;
            bus.in_data  = '0;
            for (int c = 0; c < 4; c++) begin
                if (n == 10 + c) begin
                    bus.in_valid[c]       = 1'b1;
                    bus.in_data[c*8 +: 8] = 8'(8'h10 + c);
                end
            end
            step();
            m = n + 1;
            check("t1_valid", {31'd0, bus.out_valid}, (m == 14) ? 32'd1 : 32'd0);
            check("t1_data",  bus.out_data, (m == 14) ? 32'h13121110 : 32'd0);
            check("t1_count", {16'd0, bus.out_count}, (m >= 14) ? 32'd1 : 32'd0);
        end

        // streaming, 8 back-to-back vectors
        do_reset();
        for (int n = 0; n < 25; n++) begin
            bus.in_valid = '0;
            bus.in_data  = '0;
            for (int c = 0; c < 4; c++) begin
                k = n - 10 - c;
                if (k >= 0 && k < 8) begin
                    bus.in_valid[c]       = 1'b1;
                    bus.in_data[c*8 +: 8] = lane(k, c);
                end
            end
            step();
            m    = n + 1;
            ek   = m - 14;
            expv = (ek >= 0 && ek < 8);
            expd = '0;
            if (expv) for (int c = 0; c < 4; c++) expd[c*8 +: 8] = lane(ek, c);
            expc = (m < 14) ? 0 : ((m > 21) ? 8 : m - 13);
            check("t2_valid", {31'd0, bus.out_valid}, {31'd0, expv});
            check("t2_data",  bus.out_data, expd);
            check("t2_count", {16'd0, bus.out_count}, expc);
            check("t2_err",   {31'd0, bus.misalign_err}, 32'd0);
        end

        // misalignment: column 2 one cycle late
        do_reset();
        for (int n = 0; n < 20; n++) begin
            bus.in_valid = '0;
            bus.in_data  = '0;
            for (int c = 0; c < 4; c++) begin
                if ((c != 2 && n == 10 + c) || (c == 2 && n == 13)) begin
                    bus.in_valid[c]       = 1'b1;
                    bus.in_data[c*8 +: 8] = 8'(8'h10 + c);
                end
            end
            step();
            m = n + 1;
            check("t3_valid", {31'd0, bus.out_valid}, 32'd0);
            check("t3_data",  bus.out_data, 32'd0);
            check("t3_count", {16'd0, bus.out_count}, 32'd0);
            check("t3_err",   {31'd0, bus.misalign_err}, (m >= 14) ? 32'd1 : 32'd0);
        end

        // reset mid-flight, continuing from the sticky-error state
        for (int n = 0; n < 4; n++) begin
            bus.in_valid = '0;
            bus.in_data  = '0;
            bus.in_valid[n]       = 1'b1;
            bus.in_data[n*8 +: 8] = 8'(8'hA0 + n);
            if (n == 3) begin
                bus.in_valid[0]   = 1'b1;
                bus.in_data[7:0]  = 8'hB0;
            end
            step();
        end
        check("t4_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t4_pre_data",  bus.out_data, 32'hA3A2A1A0);
        check("t4_pre_count", {16'd0, bus.out_count}, 32'd1);
        check("t4_pre_err",   {31'd0, bus.misalign_err}, 32'd1);
        bus.in_valid     = 4'b0010;
        bus.in_data      = 32'h0000B100;
        #2;
        reset = 1'b0;
        #1;
        check("t4_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_rst_data",  bus.out_data, 32'd0);
        check("t4_rst_count", {16'd0, bus.out_count}, 32'd0);
        check("t4_rst_err",   {31'd0, bus.misalign_err}, 32'd0);
        do_reset();
        for (int n = 0; n < 10; n++) begin
            bus.in_valid = '0;
            bus.in_data  = '0;
            if (n < 4) begin
                bus.in_valid[n]       = 1'b1;
                bus.in_data[n*8 +: 8] = 8'(8'hC0 + n);
            end
            step();
            m = n + 1;
            check("t4_valid", {31'd0, bus.out_valid}, (m == 4) ? 32'd1 : 32'd0);
            check("t4_data",  bus.out_data, (m == 4) ? 32'hC3C2C1C0 : 32'd0);
            check("t4_count", {16'd0, bus.out_count}, (m >= 4) ? 32'd1 : 32'd0);
            check("t4_err",   {31'd0, bus.misalign_err}, 32'd0);
        end

        // idle lanes with random data must stay gated
        do_reset();
        for (int n = 0; n < 50; n++) begin
            bus.in_valid = '0;
            bus.in_data  = $urandom;
            step();
            check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
            check("t5_data",  bus.out_data, 32'd0);
            check("t5_err",   {31'd0, bus.misalign_err}, 32'd0);
        end

        // 17 vectors through the 4-bit counter copy
        do_reset();
        for (int n = 0; n < 25; n++) begin
            bus.in_valid = '0;
            bus.in_data  = '0;
            for (int c = 0; c < 4; c++) begin
                k = n - c;
                if (k >= 0 && k < 17) begin
                    bus.in_valid[c]       = 1'b1;
                    bus.in_data[c*8 +: 8] = lane(k, c);
                end
            end
            step();
            m  = n + 1;
            ek = m - 4;
            if (ek >= 0 && ek < 17) begin
                check("t6_valid", {31'd0, bus4.out_valid}, 32'd1);
                check("t6_count", {28'd0, bus4.out_count}, (ek + 1) % 16);
            end
        end
        check("t6_wrap_end", {28'd0, bus4.out_count}, 32'd1);
        check("t6_wide_end", {16'd0, bus.out_count}, 32'd17);
        check("t6_err",      {31'd0, bus4.misalign_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
